// File: rtl/systolic_tile.sv
// Output-stationary ROWS x COLS systolic tile computing C = A*B over k_len slices.
// Define SYSTOLIC_SAT_EN to saturate accumulators instead of wrapping.
module systolic_tile #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int SUM_W  = 32,
    parameter int K_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [K_W-1:0]           k_len,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DATA_W-1:0]   a_west,
    input  logic [COLS*DATA_W-1:0]   b_north,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(ROWS)-1:0]  out_row,
    output logic [COLS*SUM_W-1:0]    out_data,
    output logic                     done
);
    localparam int RW = $clog2(ROWS);
    localparam int FW = $clog2(ROWS + COLS);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DRAIN} state_t;
    state_t state, state_nxt;

    logic [K_W-1:0] k_len_q, beat_cnt;
    logic [FW-1:0]  flush_cnt;
    logic [RW-1:0]  row_q;
    logic           done_q;
    logic           beat, adv, clr, row_acc, last_row;

    logic signed [DATA_W-1:0] a_inj [ROWS];
    logic signed [DATA_W-1:0] a_sk  [ROWS];
    logic signed [DATA_W-1:0] b_inj [COLS];
    logic signed [DATA_W-1:0] b_sk  [COLS];
    logic signed [DATA_W-1:0] a_in  [ROWS][COLS];
    logic signed [DATA_W-1:0] b_in  [ROWS][COLS];
    logic signed [DATA_W-1:0] a_pipe [ROWS][COLS-1];
    logic signed [DATA_W-1:0] b_pipe [ROWS-1][COLS];
    logic signed [SUM_W-1:0]  acc   [ROWS][COLS];

    function automatic logic signed [SUM_W-1:0] mul_ext(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        return SUM_W'(p);
    endfunction

    function automatic logic signed [SUM_W-1:0] acc_add(input logic signed [SUM_W-1:0] a,
                                                        input logic signed [SUM_W-1:0] p);
        logic signed [SUM_W-1:0] s;
        s = a + p;
`ifdef SYSTOLIC_SAT_EN
        if ((a[SUM_W-1] == p[SUM_W-1]) && (s[SUM_W-1] != a[SUM_W-1]))
            s = a[SUM_W-1] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
`endif
        return s;
    endfunction

    // Both ports use valid/ready: a transfer happens on a rising edge where valid and
    // ready are both 1; the sender holds its payload stable until that edge.
    assign beat     = (state == S_STREAM) && in_valid;
    assign adv      = beat || (state == S_FLUSH);
    assign clr      = (state == S_IDLE) && start;
    assign row_acc  = (state == S_DRAIN) && out_ready;
    assign last_row = (row_q == RW'(ROWS - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:   if (start) state_nxt = (k_len == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: begin
                in_ready = 1'b1;
                if (beat && (beat_cnt == k_len_q - K_W'(1))) state_nxt = S_FLUSH;
            end
            S_FLUSH:  if (flush_cnt == FW'(ROWS + COLS - 2)) state_nxt = S_DRAIN;
            S_DRAIN: begin
                out_valid = 1'b1;
                if (row_acc && last_row) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k_len_q   <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= row_acc && last_row;
            if (clr) begin
                k_len_q   <= k_len;
                beat_cnt  <= '0;
                flush_cnt <= '0;
                row_q     <= '0;
            end
            if (beat) beat_cnt <= beat_cnt + K_W'(1);
            if (state == S_FLUSH) flush_cnt <= flush_cnt + FW'(1);
            if (row_acc) row_q <= last_row ? '0 : row_q + RW'(1);
        end
    end

    // Row r of A enters r beats late and column c of B c beats late, so slice k
    // meets at PE(r,c) on advance step k+r+c.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_a_skew
        assign a_inj[gr] = (state == S_STREAM) ? a_west[gr*DATA_W +: DATA_W] : '0;
        if (gr == 0) begin : g_direct
            assign a_sk[gr] = a_inj[gr];
        end else begin : g_chain
            logic signed [DATA_W-1:0] chain [gr];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || clr) begin
                    for (int i = 0; i < gr; i++) chain[i] <= '0;
                end else if (adv) begin
                    chain[0] <= a_inj[gr];
                    for (int i = 1; i < gr; i++) chain[i] <= chain[i-1];
                end
            end
            assign a_sk[gr] = chain[gr-1];
        end
    end

    for (genvar gc = 0; gc < COLS; gc++) begin : g_b_skew
        assign b_inj[gc] = (state == S_STREAM) ? b_north[gc*DATA_W +: DATA_W] : '0;
        if (gc == 0) begin : g_direct
            assign b_sk[gc] = b_inj[gc];
        end else begin : g_chain
            logic signed [DATA_W-1:0] chain [gc];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || clr) begin
                    for (int i = 0; i < gc; i++) chain[i] <= '0;
                end else if (adv) begin
                    chain[0] <= b_inj[gc];
                    for (int i = 1; i < gc; i++) chain[i] <= chain[i-1];
                end
            end
            assign b_sk[gc] = chain[gc-1];
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            a_in[r][0] = a_sk[r];
            for (int c = 1; c < COLS; c++) a_in[r][c] = a_pipe[r][c-1];
        end
        for (int c = 0; c < COLS; c++) begin
            b_in[0][c] = b_sk[c];
            for (int r = 1; r < ROWS; r++) b_in[r][c] = b_pipe[r-1][c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) acc[r][c] <= '0;
                for (int c = 0; c < COLS - 1; c++) a_pipe[r][c] <= '0;
            end
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) b_pipe[r][c] <= '0;
        end else if (adv) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++)
                    acc[r][c] <= acc_add(acc[r][c], mul_ext(a_in[r][c], b_in[r][c]));
                for (int c = 0; c < COLS - 1; c++) a_pipe[r][c] <= a_in[r][c];
            end
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) b_pipe[r][c] <= b_in[r][c];
        end
    end

    always_comb begin
        out_data = '0;
        if (state == S_DRAIN)
            for (int c = 0; c < COLS; c++) out_data[c*SUM_W +: SUM_W] = acc[row_q][c];
    end

    assign out_row = row_q;
    assign done    = done_q;

endmodule

// File: tb/tb_systolic_tile.sv
// Bench for systolic_tile: a 32-bit and a 16-bit accumulator instance run the same
// jobs in lockstep and are checked against a matrix-product model.
module tb_systolic_tile;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int SW   = 32;
    localparam int SW16 = 16;
    localparam int KW   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [ROWS*DW-1:0] a_west = '0;
    logic [COLS*DW-1:0] b_north = '0;

    logic busy, in_ready, out_valid, done;
    logic [1:0] out_row;
    logic [COLS*SW-1:0] out_data;
    logic busy16, in_ready16, out_valid16, done16;
    logic [1:0] out_row16;
    logic [COLS*SW16-1:0] out_data16;

    int total = 0;
    int bad = 0;

    int am [ROWS][256];
    int bm [256][COLS];
    logic [COLS*SW-1:0]   exp_q[$];
    logic [COLS*SW16-1:0] exp16_q[$];

    systolic_tile #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .SUM_W(SW), .K_W(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_west(a_west), .b_north(b_north),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_data(out_data), .done(done)
    );

    systolic_tile #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .SUM_W(SW16), .K_W(KW)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy16),
        .in_valid(in_valid), .in_ready(in_ready16), .a_west(a_west), .b_north(b_north),
        .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16),
        .out_data(out_data16), .done(done16)
    );

    always #5 clk = ~clk;

    // Reference: C[r][c] accumulated slice by slice, wrapped or clamped to w bits.
    function automatic longint model_c(int r, int c, int k, int w);
        longint s, half;
        half = longint'(1) << (w - 1);
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
            s = s + longint'(am[r][kk]) * longint'(bm[kk][c]);
`ifdef SYSTOLIC_SAT_EN
            if (s > half - 1) s = half - 1;
            if (s < -half) s = -half;
`else
            s = s & ((half << 1) - 1);
            if (s >= half) s = s - (half << 1);
`endif
        end
        return s;
    endfunction

    task automatic fill_const(input int av, input int bv);
        for (int i = 0; i < 256; i++) begin
            for (int r = 0; r < ROWS; r++) am[r][i] = av;
            for (int c = 0; c < COLS; c++) bm[i][c] = bv;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            for (int r = 0; r < ROWS; r++) am[r][i] = $urandom_range(0, 255) - 128;
            for (int c = 0; c < COLS; c++) bm[i][c] = $urandom_range(0, 255) - 128;
        end
    endtask

    task automatic drive_beat(input int i);
        for (int r = 0; r < ROWS; r++) a_west[r*DW +: DW] = DW'(am[r][i]);
        for (int c = 0; c < COLS; c++) b_north[c*DW +: DW] = DW'(bm[i][c]);
    endtask

    // vmode: 0 continuous, 1 every other cycle, 2 random. rmode: 0 always, 1 random, 2 stall row 1.
    task automatic run_job(input int k, input int vmode, input int rmode, input bit noise,
                           input string tag);
        int beats, cyc, lat, row, stall;
        logic [COLS*SW-1:0]   e32;
        logic [COLS*SW16-1:0] e16;
        exp_q.delete();
        exp16_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                e32[c*SW +: SW]     = SW'(model_c(r, c, k, SW));
                e16[c*SW16 +: SW16] = SW16'(model_c(r, c, k, SW16));
            end
            exp_q.push_back(e32);
            exp16_q.push_back(e16);
        end

        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;

        beats = 0;
        cyc = 0;
        while (beats < k && cyc < k * 4 + 40) begin
            in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
            drive_beat(beats);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                k_len = KW'($urandom);
            end
            @(negedge clk);
            total++;
            if ({in_ready, in_ready16, busy, busy16, out_valid} !== 5'b11110) begin
                bad++;
                $display("FAIL %s stream_flags got=%b exp=11110", tag,
                         {in_ready, in_ready16, busy, busy16, out_valid});
            end
            @(posedge clk); #1;
            if (in_valid) beats++;
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (beats < k) begin
            bad++;
            $display("FAIL %s feed_timeout got=%0d beats exp=%0d", tag, beats, k);
        end

        if (k > 0) begin
            lat = 0;
            forever begin
                @(negedge clk);
                if (out_valid === 1'b1 || lat >= 40) break;
                total++;
                if ({in_ready, busy} !== 2'b01) begin
                    bad++;
                    $display("FAIL %s flush_flags got=%b exp=01", tag, {in_ready, busy});
                end
                lat++;
                @(posedge clk); #1;
            end
            total++;
            if (lat != ROWS + COLS - 1) begin
                bad++;
                $display("FAIL %s drain_latency got=%0d exp=%0d", tag, lat, ROWS + COLS - 1);
            end
            @(posedge clk); #1;
        end

        row = 0;
        stall = 0;
        cyc = 0;
        while (row < ROWS && cyc < 200) begin
            if (rmode == 0) out_ready = 1'b1;
            else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (row == 1 && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else out_ready = 1'b1;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                k_len = KW'($urandom);
            end
            @(negedge clk);
            total++;
            if ({out_valid, out_valid16, busy, in_ready, done, done16} !== 6'b111000) begin
                bad++;
                $display("FAIL %s drain_flags got=%b exp=111000", tag,
                         {out_valid, out_valid16, busy, in_ready, done, done16});
            end
            total++;
            if (out_row !== 2'(row) || out_row16 !== 2'(row)) begin
                bad++;
                $display("FAIL %s out_row got=%0d/%0d exp=%0d", tag, out_row, out_row16, row);
            end
            total++;
            if (out_data !== exp_q[0]) begin
                bad++;
                $display("FAIL %s out_data row%0d got=%h exp=%h", tag, row, out_data, exp_q[0]);
            end
            total++;
            if (out_data16 !== exp16_q[0]) begin
                bad++;
                $display("FAIL %s out_data16 row%0d got=%h exp=%h", tag, row, out_data16, exp16_q[0]);
            end
            @(posedge clk); #1;
            if (out_ready) begin
                void'(exp_q.pop_front());
                void'(exp16_q.pop_front());
                row++;
            end
            cyc++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        if (row < ROWS) begin
            bad++;
            $display("FAIL %s drain_timeout got=%0d rows exp=%0d", tag, row, ROWS);
        end

        @(negedge clk);
        total++;
        if ({done, done16, busy, busy16, out_valid} !== 5'b11000 || out_data !== '0) begin
            bad++;
            $display("FAIL %s done_pulse got=%b data=%h exp=11000 data=0", tag,
                     {done, done16, busy, busy16, out_valid}, out_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({done, done16} !== 2'b00) begin
            bad++;
            $display("FAIL %s done_width got=%b exp=00", tag, {done, done16});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, in_ready, out_valid, done, busy16, in_ready16, out_valid16, done16} !== 8'b0
            || out_row !== 2'b0 || out_data !== '0 || out_data16 !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b row=%0d data=%h exp=0",
                     {busy, in_ready, out_valid, done}, out_row, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        for (int i = 0; i < 256; i++) begin
            for (int r = 0; r < ROWS; r++) am[r][i] = (r == i) ? 1 : 0;
            for (int c = 0; c < COLS; c++) bm[i][c] = i * COLS + c + 1;
        end
        run_job(4, 0, 0, 1'b0, "identity");
    endtask

    task automatic test_gap_valid();
        fill_const(2, 3);
        run_job(5, 1, 0, 1'b0, "gap_valid");
    endtask

    task automatic test_backpressure();
        fill_random();
        run_job($urandom_range(1, 8), 0, 2, 1'b0, "backpressure");
    endtask

    task automatic test_overflow();
        fill_const(127, 127);
        run_job(4, 0, 0, 1'b0, "overflow_pos");
        fill_const(-128, -128);
        run_job(255, 0, 0, 1'b0, "overflow_long");
    endtask

    task automatic test_mid_reset();
        fill_random();
        @(posedge clk); #1;
        start = 1'b1;
        k_len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            drive_beat(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        if ({busy, busy16} !== 2'b11) begin
            bad++;
            $display("FAIL mid_reset_busy got=%b exp=11", {busy, busy16});
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, in_ready, out_valid, done, busy16, in_ready16, out_valid16, done16} !== 8'b0
            || out_row !== 2'b0 || out_row16 !== 2'b0 || out_data !== '0 || out_data16 !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%b row=%0d data=%h exp=0",
                     {busy, in_ready, out_valid, done}, out_row, out_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill_const(1, 1);
        run_job(1, 0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_zero_len();
        fill_random();
        run_job(0, 0, 1, 1'b0, "zero_len");
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 4; j++) begin
            fill_random();
            run_job($urandom_range(1, 12), 2, 1, 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_gap_valid();
        test_backpressure();
        test_overflow();
        test_mid_reset();
        test_zero_len();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
